memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
// - Shares the single RAM port between the instruction-fetch requester (i*) and the data requester (d*).
// - Sits between the datapath's fetch/load-store interfaces and RAM.
// - Sequences each access from grant to RAM ACCESS and back, returning wait/load to the owning requester.
// - Recovers from RAM errors and hung transfers.
// PARAMETERS
// - ADDR_W   32   address width of requesters and RAM
// - DATA_W   32   data width of load/store paths
// - TIMEOUT  255  max cycles in a grant state without ACCESS before abort (>=2)
// PORTS
// - CLK        in   1       single clock; all state on rising edge
// - RST        in   1       asynchronous reset, active-high
// - iREN       in   1       instruction read request
// - iaddr      in   ADDR_W  instruction address
// - iwait      out  1       1 = fetch not yet complete
// - iload      out  DATA_W  fetched word, valid when iREN & !iwait
// - dREN       in   1       data read request
// - dWEN       in   1       data write request
// - daddr      in   ADDR_W  data address
// - dstore     in   DATA_W  write data
// - dwait      out  1       1 = data access not yet complete
// - dload      out  DATA_W  read word, valid when dREN & !dwait
// - ramREN     out  1       RAM read enable
// - ramWEN     out  1       RAM write enable
// - ramaddr    out  ADDR_W  RAM address
// - ramstore   out  DATA_W  RAM write data
// - ramload    in   DATA_W  RAM read data
// - ramstate   in   2       FREE=0 BUSY=1 ACCESS=2 ERROR=3
// - ramerr     out  1       sticky: RAM ERROR or timeout occurred
// BEHAVIOUR
// - FSM states: IDLE, IGNT, DGNT, ERR. Reset: IDLE; ramREN/ramWEN/ramaddr/ramstore=0; ramerr=0; timeout counter=0.
// - Reset is asynchronous: asserting RST mid-transfer drops all RAM enables in the same cycle and discards the transfer.
// - IDLE: RAM outputs 0; both waits follow their requests (iwait=iREN, dwait=dREN|dWEN).
//   - At the clock edge, grant goes to the pending requester.
//   - If both are pending, DGNT wins (fixed priority).
// - IGNT: ramREN=1, ramaddr=iaddr. DGNT: ramaddr=daddr, ramstore=dstore.
//   - In DGNT, dWEN=1 drives ramWEN=1 and ramREN=0; otherwise ramREN=dREN.
//   - If dREN and dWEN are both high, the write wins.
// - Completion: in a grant state with ramstate==ACCESS, the owner's wait=0 combinationally in that cycle.
//   - Load path is combinational: iload/dload=ramload.
//   - Next state is IDLE, which gives one turnaround cycle.
//   - Minimum latency is 2 cycles from request assertion (IDLE cycle + grant cycle).
// - Non-owner wait stays 1 throughout. Loads are 0 when the requester is not completing.
// - Owner drops its request mid-grant: abort; enables drop combinationally; next state is IDLE; no completion.
// - Timeout counter:
//   - Clears on entry to any grant state.
//   - Increments each grant cycle without ACCESS.
//   - Saturates at TIMEOUT.
// - ramstate==ERROR, or counter==TIMEOUT-1 without ACCESS, in a grant state: next state ERR.
// - ERR (one cycle):
//   - RAM outputs 0.
//   - The aborted owner sees wait=0 with load=0, so the core does not hang.
//   - ramerr is set and stays 1 until RST.
//   - Next state is IDLE.
// - Address/data widths pass through unchanged; no alignment checks.
// CONFIGURATION
// - MEMORY_ARBITER_RR_EN defined: round-robin arbitration.
//   - A 1-bit last-owner register (reset = I) decides on a simultaneous request; the requester that did not own the last completed or aborted grant wins.
//   - A lone request is granted immediately.
// - Undefined: fixed data-over-instruction priority as above; no last-owner register.
// TESTING
// - Fetch only, iREN=1, iaddr=0x40, RAM returns ACCESS in the first grant cycle, ramload=0x3C010001 -> ramREN=1 with ramaddr=0x40 in cycle 2; iwait=0 and iload=0x3C010001 in cycle 2; IDLE in cycle 3.
// - Store, dWEN=dREN=1, daddr=0x80, dstore=0xDEADBEEF, BUSY for 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low only in the ACCESS cycle.
// - iREN and dREN raised in the same cycle -> DGNT first and iwait held 1; after the data completes plus one IDLE cycle, IGNT. With MEMORY_ARBITER_RR_EN after a prior D grant -> IGNT first.
// - TIMEOUT=4, ramstate stuck BUSY on a fetch -> ERR after 4 grant cycles; iwait=0 with iload=0; ramerr=1 and it stays 1 through subsequent good accesses.
// - RST pulsed during DGNT while BUSY -> ramREN/ramWEN=0 immediately, state IDLE, ramerr=0; a fresh iREN completes normally.
// - ramstate=ERROR in DGNT -> ERR next cycle; dwait=0, dload=0; ramerr=1.

Source files
------------

// File: rtl/memory_arbiter.sv
// Purpose : shares one RAM port between the instruction-fetch (i*) and data (d*) requesters.
// Latency : 2 cycles minimum from request to completion (IDLE cycle + grant cycle), then one IDLE turnaround.
// Backpressure: the RAM stalls the owner through ramstate BUSY; the non-owner holds wait=1 until it is granted.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   iREN, iaddr -> iwait, iload               instruction fetch requester
//   dREN, dWEN, daddr, dstore -> dwait, dload data load/store requester
//   ramREN, ramWEN, ramaddr, ramstore <- ramload, ramstate  RAM port
//   ramerr                    sticky flag: RAM ERROR or grant timeout since reset
//
// Build option: define MEMORY_ARBITER_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise data always beats instruction.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ramerr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             err_is_d;   // which requester owned the grant that failed
    logic             ramerr_q;
    logic             d_req;
    logic             ram_access;
    logic             ram_error;
    logic             timed_out;
    logic             prefer_d;
    logic             in_grant;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == RAM_ACCESS);
    assign ram_error  = (ramstate == RAM_ERROR);
    assign timed_out  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign in_grant   = (state == IGNT) || (state == DGNT);
    assign ramerr     = ramerr_q;

`ifdef MEMORY_ARBITER_RR_EN
    // Remembers the owner of the last finished grant (completed or aborted).
    logic last_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_d <= 1'b0;
        end else if (in_grant && (next_state != state)) begin
            last_d <= (state == DGNT);
        end
    end

    // On a tie the requester that did not own the last grant wins.
    assign prefer_d = ~last_d;
`else
    assign prefer_d = 1'b1;
`endif

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = iREN;
        dwait      = d_req;
        iload      = '0;
        dload      = '0;

        case (state)
            IDLE: begin
                if (d_req && (!iREN || prefer_d)) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
            end

            IGNT: begin
                dwait = 1'b1;
                if (!iREN) begin
                    // Owner withdrew: abandon the access with no completion.
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iwait   = 1'b1;
                    if (ram_access) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end else if (ram_error || timed_out) begin
                        next_state = ERR;
                    end
                end
            end

            DGNT: begin
                iwait = 1'b1;
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    // A simultaneous read and write resolves to the write.
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    dwait    = 1'b1;
                    if (ram_access) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                    end else if (ram_error || timed_out) begin
                        next_state = ERR;
                    end
                end
            end

            ERR: begin
                // Release the stuck owner with a zero load so the core can move on.
                if (err_is_d) begin
                    dwait = 1'b0;
                end else begin
                    iwait = 1'b0;
                end
                next_state = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            err_is_d <= 1'b0;
            ramerr_q <= 1'b0;
        end else begin
            state <= next_state;

            if ((state == IDLE) && (next_state != IDLE)) begin
                tmo_cnt <= '0;
            end else if (in_grant && !ram_access && (tmo_cnt != CNT_W'(TIMEOUT))) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (next_state == ERR) begin
                err_is_d <= (state == DGNT);
                ramerr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int TMO = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ramerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;
    // Reference state: who owned the last finished grant, and whether an error was seen.
    logic exp_last_d = 1'b0;
    logic exp_err    = 1'b0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    always #5 CLK = ~CLK;

    // Move just past the next rising edge; inputs are driven there and outputs sampled 1 later.
    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0h exp=0", ramREN); end
        total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0h exp=0", ramWEN); end
        total++; if (ramaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", ramaddr); end
        total++; if (ramstore !== 32'h0) begin bad++; $display("FAIL reset_store got=%0h exp=0", ramstore); end
        total++; if (ramerr !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", ramerr); end
        total++; if ({iwait, dwait} !== 2'b00) begin bad++; $display("FAIL reset_waits got=%b exp=00", {iwait, dwait}); end
        RST = 1'b0;
        exp_last_d = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic test_fetch;
        tick; iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h3C010001; #1;
        total++; if ({ramREN, iwait} !== 2'b01) begin bad++; $display("FAIL fetch_c1 ren,iwait got=%b exp=01", {ramREN, iwait}); end
        tick; #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin bad++; $display("FAIL fetch_c2_ram ren=%0h addr=%0h exp 1/40", ramREN, ramaddr); end
        total++; if (iwait !== 1'b0 || iload !== 32'h3C010001) begin bad++; $display("FAIL fetch_c2_load iwait=%0h iload=%0h exp 0/3c010001", iwait, iload); end
        tick; iREN = 0; #1;
        total++; if (ramREN !== 1'b0 || iload !== 32'h0) begin bad++; $display("FAIL fetch_c3_idle ren=%0h iload=%0h exp 0/0", ramREN, iload); end
        exp_last_d = 1'b0;
    endtask

    task automatic test_store;
        tick; dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = BUSY; #1;
        total++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin bad++; $display("FAIL store_idle dwait=%0h wen=%0h exp 1/0", dwait, ramWEN); end
        for (int k = 1; k <= 4; k++) begin
            tick; ramstate = (k == 4) ? ACCESS : BUSY; #1;
            total++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h80) begin
                bad++; $display("FAIL store_ram c%0d wen=%0h ren=%0h st=%0h addr=%0h", k, ramWEN, ramREN, ramstore, ramaddr);
            end
            total++; if (dwait !== (k != 4)) begin bad++; $display("FAIL store_dwait c%0d got=%0h exp=%0h", k, dwait, (k != 4)); end
        end
        tick; dWEN = 0; dREN = 0; ramstate = FREE; #1;
        total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL store_after wen=%0h exp=0", ramWEN); end
        exp_last_d = 1'b1;
    endtask

    task automatic test_priority;
        logic first_d;
`ifdef MEMORY_ARBITER_RR_EN
        first_d = ~exp_last_d;
`else
        first_d = 1'b1;
`endif
        tick; iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h300; daddr = 32'h400;
        ramstate = ACCESS; ramload = 32'h55; #1;
        total++; if ({iwait, dwait} !== 2'b11) begin bad++; $display("FAIL prio_idle waits=%b exp=11", {iwait, dwait}); end
        tick; #1;
        total++; if (ramaddr !== (first_d ? 32'h400 : 32'h300)) begin bad++; $display("FAIL prio_first_addr got=%0h", ramaddr); end
        total++; if ({iwait, dwait} !== (first_d ? 2'b10 : 2'b01)) begin bad++; $display("FAIL prio_first_waits got=%b first_d=%0d", {iwait, dwait}, first_d); end
        tick; if (first_d) dREN = 0; else iREN = 0; #1;
        total++; if (ramREN !== 1'b0 || (first_d ? iwait : dwait) !== 1'b1) begin bad++; $display("FAIL prio_turn ren=%0h iwait=%0h dwait=%0h", ramREN, iwait, dwait); end
        tick; #1;
        total++; if (ramaddr !== (first_d ? 32'h300 : 32'h400) || ramREN !== 1'b1) begin bad++; $display("FAIL prio_second addr=%0h ren=%0h", ramaddr, ramREN); end
        total++; if ((first_d ? iwait : dwait) !== 1'b0) begin bad++; $display("FAIL prio_second_wait got=%0h exp=0", first_d ? iwait : dwait); end
        tick; iREN = 0; dREN = 0; ramstate = FREE; #1;
        exp_last_d = ~first_d;
    endtask

    task automatic test_timeout;
        tick; iREN = 1; iaddr = 32'h44; ramstate = BUSY; ramload = 32'hCAFE; #1;
        for (int k = 1; k <= TMO; k++) begin
            tick; #1;
            total++; if (ramREN !== 1'b1 || iwait !== 1'b1) begin bad++; $display("FAIL tmo_grant c%0d ren=%0h iwait=%0h exp 1/1", k, ramREN, iwait); end
        end
        tick; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'h0 || ramREN !== 1'b0) begin bad++; $display("FAIL tmo_err iwait=%0h iload=%0h ren=%0h exp 0/0/0", iwait, iload, ramREN); end
        total++; if (ramerr !== 1'b1) begin bad++; $display("FAIL tmo_ramerr got=%0h exp=1", ramerr); end
        tick; iREN = 0; ramstate = FREE; #1;
        tick; iREN = 1; ramstate = ACCESS; #1;
        tick; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'hCAFE) begin bad++; $display("FAIL tmo_good iwait=%0h iload=%0h", iwait, iload); end
        total++; if (ramerr !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0h exp=1", ramerr); end
        tick; iREN = 0; ramstate = FREE; #1;
        exp_last_d = 1'b0;
        exp_err    = 1'b1;
    endtask

    task automatic test_reset_mid;
        tick; dWEN = 1; dREN = 0; daddr = 32'h90; dstore = 32'h1234; ramstate = BUSY; #1;
        tick; #1;
        total++; if (ramWEN !== 1'b1) begin bad++; $display("FAIL rstmid_pre wen=%0h exp=1", ramWEN); end
        RST = 1'b1; #1;
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin bad++; $display("FAIL rstmid_drop wen=%0h ren=%0h exp 0/0", ramWEN, ramREN); end
        total++; if (ramerr !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%0h exp=0", ramerr); end
        #1; RST = 1'b0; dWEN = 0;
        exp_last_d = 1'b0;
        exp_err    = 1'b0;
        tick; iREN = 1; iaddr = 32'h100; ramstate = ACCESS; ramload = 32'h12345678; #1;
        total++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL rstmid_idle iwait=%0h ren=%0h exp 1/0", iwait, ramREN); end
        tick; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'h12345678 || ramaddr !== 32'h100) begin bad++; $display("FAIL rstmid_fetch iwait=%0h iload=%0h addr=%0h", iwait, iload, ramaddr); end
        tick; iREN = 0; ramstate = FREE; #1;
    endtask

    task automatic test_ram_error;
        tick; dREN = 1; dWEN = 0; daddr = 32'h200; ramstate = FREE; ramload = 32'h7777; #1;
        tick; ramstate = ERROR; #1;
        total++; if (dwait !== 1'b1 || ramREN !== 1'b1) begin bad++; $display("FAIL rerr_grant dwait=%0h ren=%0h exp 1/1", dwait, ramREN); end
        tick; #1;
        total++; if (dwait !== 1'b0 || dload !== 32'h0) begin bad++; $display("FAIL rerr_err dwait=%0h dload=%0h exp 0/0", dwait, dload); end
        total++; if (ramerr !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL rerr_flag ramerr=%0h ren=%0h exp 1/0", ramerr, ramREN); end
        tick; dREN = 0; ramstate = FREE; #1;
        exp_last_d = 1'b1;
        exp_err    = 1'b1;
    endtask

    // Random single-requester transactions: the RAM answers after nbusy BUSY cycles; the
    // model completes on grant cycle nbusy+1 if that is within TIMEOUT, otherwise errors out
    // after TIMEOUT grant cycles.
    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          nbusy;
            int          ngrant;
            logic [31:0] a, wd, rd, own_load;
            logic        done, own_wait, oth_wait, exp_ren, exp_wen;
            kind  = $urandom_range(0, 2);
            nbusy = $urandom_range(0, 5);
            a = $urandom; wd = $urandom; rd = $urandom;
            ngrant = (nbusy < TMO) ? nbusy + 1 : TMO;
            exp_ren = (kind != 2);
            exp_wen = (kind == 2);

            tick;
            iREN = (kind == 0);
            dWEN = (kind == 2);
            dREN = (kind == 1) || ((kind == 2) && ($urandom_range(0, 1) == 1));
            iaddr = a; daddr = a; dstore = wd; ramload = rd; ramstate = BUSY;
            #1;
            own_wait = (kind == 0) ? iwait : dwait;
            total++; if (own_wait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("FAIL rnd_idle t%0d wait=%0h ren=%0h wen=%0h", t, own_wait, ramREN, ramWEN); end

            for (int k = 1; k <= ngrant; k++) begin
                tick;
                ramstate = (k == nbusy + 1) ? ACCESS : BUSY;
                #1;
                done     = (k == nbusy + 1);
                own_wait = (kind == 0) ? iwait : dwait;
                oth_wait = (kind == 0) ? dwait : iwait;
                own_load = (kind == 0) ? iload : dload;
                total++;
                if (ramREN !== exp_ren || ramWEN !== exp_wen || ramaddr !== a ||
                    ramstore !== ((kind == 0) ? 32'h0 : wd)) begin
                    bad++; $display("FAIL rnd_ram t%0d k%0d ren=%0h wen=%0h addr=%0h st=%0h exp addr=%0h", t, k, ramREN, ramWEN, ramaddr, ramstore, a);
                end
                total++; if (own_wait !== !done || oth_wait !== 1'b1) begin bad++; $display("FAIL rnd_wait t%0d k%0d own=%0h oth=%0h exp own=%0h", t, k, own_wait, oth_wait, !done); end
                if (kind != 2 || !done) begin
                    total++; if (own_load !== (done ? rd : 32'h0)) begin bad++; $display("FAIL rnd_load t%0d k%0d got=%0h exp=%0h", t, k, own_load, done ? rd : 32'h0); end
                end
            end

            if (nbusy >= TMO) begin
                tick; #1;
                own_wait = (kind == 0) ? iwait : dwait;
                own_load = (kind == 0) ? iload : dload;
                total++; if (own_wait !== 1'b0 || own_load !== 32'h0 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("FAIL rnd_err t%0d wait=%0h load=%0h ren=%0h wen=%0h", t, own_wait, own_load, ramREN, ramWEN); end
                exp_err = 1'b1;
            end

            tick; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE; #1;
            total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramerr !== exp_err) begin bad++; $display("FAIL rnd_after t%0d ren=%0h wen=%0h ramerr=%0h exp err=%0h", t, ramREN, ramWEN, ramerr, exp_err); end
            exp_last_d = (kind != 0);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store;
        test_priority;
        test_timeout;
        test_reset_mid;
        test_ram_error;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
